// File: rtl/ternary_array_seq_2ghz.sv
// Tile sequencer for the pipelined ternary systolic array: clear, weight load,
// activation streaming with backpressure, pipeline drain, plus utilisation counters.
module ternary_array_seq_2ghz #(
  parameter int ARRAY_SIZE = 64,
  parameter int PIPE_DEPTH = 2,
  parameter int K_BITS     = 16,
  parameter int CNT_BITS   = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [K_BITS-1:0]             k_len,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted,
  input  logic                          act_valid,
  output logic                          act_ready,
  output logic [$clog2(ARRAY_SIZE)-1:0] wgt_row,
  output logic                          array_clear,
  output logic                          array_weight_load,
  output logic                          array_enable,
  output logic [CNT_BITS-1:0]           busy_cycles,
  output logic [CNT_BITS-1:0]           stall_cycles
);

  localparam int DRAIN_CYCLES = PIPE_DEPTH * ARRAY_SIZE + ARRAY_SIZE - 1;
  localparam int ROW_W        = $clog2(ARRAY_SIZE);
  localparam int DRN_W        = $clog2(DRAIN_CYCLES + 1);

  localparam logic [ROW_W-1:0]    ROW_LAST = ROW_W'(ARRAY_SIZE - 1);
  localparam logic [DRN_W-1:0]    DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};

  // S_ABORT is the single idle cycle that follows an abort; it behaves as
  // IDLE (accepts start, not busy) but also raises array_clear and aborted.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ABORT,
    S_CLR,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [K_BITS-1:0]   k_q, k_d;
  logic [K_BITS-1:0]   beat_q, beat_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [DRN_W-1:0]    drain_q, drain_d;
  logic [CNT_BITS-1:0] busy_cnt_q, busy_cnt_d;
  logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;

  logic is_idle;
  logic stall_now;

  assign is_idle   = (state_q == S_IDLE) || (state_q == S_ABORT);
  assign stall_now = (state_q == S_STREAM) && !act_valid;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    beat_d  = beat_q;
    row_d   = row_q;
    drain_d = drain_q;

    unique case (state_q)
      S_IDLE, S_ABORT: begin
        if (start && !abort) begin
          k_d     = k_len;
          state_d = S_CLR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR: begin
        beat_d  = '0;
        row_d   = '0;
        drain_d = '0;
        state_d = (k_q == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (row_q == ROW_LAST) begin
          row_d   = '0;
          state_d = S_STREAM;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      S_STREAM: begin
        if (act_valid) begin
          if (beat_q == k_q - K_BITS'(1)) begin
            beat_d  = '0;
            state_d = S_DRAIN;
          end else begin
            beat_d = beat_q + K_BITS'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRN_LAST) begin
          drain_d = '0;
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every other transition out of a busy state.
    if (abort && !is_idle) begin
      state_d = S_ABORT;
      beat_d  = '0;
      row_d   = '0;
      drain_d = '0;
    end
  end

  always_comb begin
    busy_cnt_d  = busy_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!is_idle && (busy_cnt_q != CNT_MAX)) begin
      busy_cnt_d = busy_cnt_q + CNT_BITS'(1);
    end
    if (stall_now && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      beat_q      <= '0;
      row_q       <= '0;
      drain_q     <= '0;
      busy_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      beat_q      <= beat_d;
      row_q       <= row_d;
      drain_q     <= drain_d;
      busy_cnt_q  <= busy_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Only array_enable in STREAM looks at an input; everything else is state-decoded.
  assign busy              = !is_idle;
  assign done              = (state_q == S_DONE);
  assign aborted           = (state_q == S_ABORT);
  assign act_ready         = (state_q == S_STREAM);
  assign wgt_row           = row_q;
  assign array_clear       = (state_q == S_CLR) || (state_q == S_ABORT);
  assign array_weight_load = (state_q == S_LOAD);
  assign array_enable      = ((state_q == S_STREAM) && act_valid) || (state_q == S_DRAIN);
  assign busy_cycles       = busy_cnt_q;
  assign stall_cycles      = stall_cnt_q;

endmodule

// File: tb/tb_ternary_array_seq_2ghz.sv
// Directed bench for the tile sequencer at N=4, PIPE_DEPTH=2 (drain 11 cycles);
// a second instance with 4-bit counters shows counter saturation.
module tb_ternary_array_seq_2ghz;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] k_len;
  logic        act_valid;

  logic        busy, done, aborted, act_ready, array_clear, array_weight_load, array_enable;
  logic [1:0]  wgt_row;
  logic [31:0] busy_cycles, stall_cycles;

  logic        s_busy, s_done, s_aborted, s_act_ready, s_array_clear, s_array_weight_load, s_array_enable;
  logic [1:0]  s_wgt_row;
  logic [3:0]  s_busy_cycles, s_stall_cycles;

  always #5 clk = ~clk;

  ternary_array_seq_2ghz #(.ARRAY_SIZE(4), .PIPE_DEPTH(2), .K_BITS(16), .CNT_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .k_len(k_len),
    .busy(busy), .done(done), .aborted(aborted), .act_valid(act_valid),
    .act_ready(act_ready), .wgt_row(wgt_row), .array_clear(array_clear),
    .array_weight_load(array_weight_load), .array_enable(array_enable),
    .busy_cycles(busy_cycles), .stall_cycles(stall_cycles)
  );

  ternary_array_seq_2ghz #(.ARRAY_SIZE(4), .PIPE_DEPTH(2), .K_BITS(16), .CNT_BITS(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .k_len(k_len),
    .busy(s_busy), .done(s_done), .aborted(s_aborted), .act_valid(act_valid),
    .act_ready(s_act_ready), .wgt_row(s_wgt_row), .array_clear(s_array_clear),
    .array_weight_load(s_array_weight_load), .array_enable(s_array_enable),
    .busy_cycles(s_busy_cycles), .stall_cycles(s_stall_cycles)
  );

  // Masks: bit c set means the signal is high in cycle c, start is in cycle 0.
  typedef struct {
    logic [15:0] k;
    logic [31:0] vlow;
    int          abort_c;
    int          start2_c;
    logic [31:0] clr;
    logic [31:0] ld;
    logic [31:0] rdy;
    logic [31:0] en;
    logic [31:0] dn;
    logic [31:0] ab;
    int          busy_n;
    int          stall_n;
  } vec_t;

  vec_t vecs[9];
  vec_t post_rst;

  int checks   = 0;
  int failures = 0;
  int exp_busy = 0;
  int exp_stall = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] m_clr, m_ld, m_rdy, m_en, m_dn, m_ab;
    int load_idx, row_err;
    m_clr = '0; m_ld = '0; m_rdy = '0; m_en = '0; m_dn = '0; m_ab = '0;
    load_idx = 0; row_err = 0;
    for (int c = 0; c < 32; c++) begin
      start     = (c == 0) || (c == v.start2_c);
      abort     = (c == v.abort_c);
      k_len     = v.k;
      act_valid = !v.vlow[c];
      @(negedge clk);
      m_clr[c] = array_clear;
      m_ld[c]  = array_weight_load;
      m_rdy[c] = act_ready;
      m_en[c]  = array_enable;
      m_dn[c]  = done;
      m_ab[c]  = aborted;
      if (array_weight_load) begin
        if (int'(wgt_row) != load_idx) row_err++;
        load_idx++;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0; abort = 1'b0; act_valid = 1'b0;
    exp_busy  += v.busy_n;
    exp_stall += v.stall_n;
    chk($sformatf("v%0d array_clear", idx),       64'(m_clr), 64'(v.clr));
    chk($sformatf("v%0d array_weight_load", idx), 64'(m_ld),  64'(v.ld));
    chk($sformatf("v%0d act_ready", idx),         64'(m_rdy), 64'(v.rdy));
    chk($sformatf("v%0d array_enable", idx),      64'(m_en),  64'(v.en));
    chk($sformatf("v%0d done", idx),              64'(m_dn),  64'(v.dn));
    chk($sformatf("v%0d aborted", idx),           64'(m_ab),  64'(v.ab));
    chk($sformatf("v%0d wgt_row_errors", idx),    64'(row_err), 64'(0));
    chk($sformatf("v%0d busy_cycles", idx),       64'(busy_cycles),  64'(exp_busy));
    chk($sformatf("v%0d stall_cycles", idx),      64'(stall_cycles), 64'(exp_stall));
    chk($sformatf("v%0d sat_busy_cycles", idx),   64'(s_busy_cycles),  64'(sat15(exp_busy)));
    chk($sformatf("v%0d sat_stall_cycles", idx),  64'(s_stall_cycles), 64'(sat15(exp_stall)));
    $display("vec %0d k=%0d clr=%h ld=%h rdy=%h en=%h done=%h ab=%h busy_cycles=%0d stall_cycles=%0d sat_busy=%0d",
             idx, v.k, m_clr, m_ld, m_rdy, m_en, m_dn, m_ab, busy_cycles, stall_cycles, s_busy_cycles);
  endtask

  function automatic logic [63:0] out_bundle();
    return {busy, done, aborted, act_ready, array_clear, array_weight_load, array_enable,
            wgt_row, busy_cycles[15:0], stall_cycles[15:0], s_busy_cycles, s_stall_cycles};
  endfunction

  initial begin
    //          k      vlow      abort start2 clr        ld      rdy      en          done        ab        busy stall
    vecs[0] = '{16'd3, 32'h0,    -1,   -1,    32'h2,     32'h3C, 32'h1C0, 32'hFFFC0,  32'h100000, 32'h0,    20,  0};
    vecs[1] = '{16'd3, 32'h180,  -1,   -1,    32'h2,     32'h3C, 32'h7C0, 32'h3FFE40, 32'h400000, 32'h0,    22,  2};
    vecs[2] = '{16'd0, 32'h0,    -1,   -1,    32'h2,     32'h0,  32'h0,   32'h0,      32'h4,      32'h0,    2,   0};
    vecs[3] = '{16'd3, 32'h0,    12,   -1,    32'h2002,  32'h3C, 32'h1C0, 32'h1FC0,   32'h0,      32'h2000, 12,  0};
    vecs[4] = '{16'd3, 32'h0,    0,    -1,    32'h0,     32'h0,  32'h0,   32'h0,      32'h0,      32'h0,    0,   0};
    vecs[5] = '{16'd2, 32'h0,    3,    -1,    32'h12,    32'hC,  32'h0,   32'h0,      32'h0,      32'h10,   3,   0};
    vecs[6] = '{16'd1, 32'h40,   -1,   -1,    32'h2,     32'h3C, 32'hC0,  32'h7FF80,  32'h80000,  32'h0,    19,  1};
    vecs[7] = '{16'd3, 32'h0,    7,    -1,    32'h102,   32'h3C, 32'hC0,  32'hC0,     32'h0,      32'h100,  7,   0};
    vecs[8] = '{16'd0, 32'h0,    5,    2,     32'h2,     32'h0,  32'h0,   32'h0,      32'h4,      32'h0,    2,   0};
    post_rst = '{16'd2, 32'h0,   -1,   -1,    32'h2,     32'h3C, 32'hC0,  32'h7FFC0,  32'h80000,  32'h0,    19,  0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; k_len = '0; act_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", out_bundle(), 64'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset in the middle of STREAM: outputs must drop before the next edge.
    for (int c = 0; c < 7; c++) begin
      start = (c == 0); k_len = 16'd3; act_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    @(negedge clk);
    chk("mid_stream_ready", 64'(act_ready), 64'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_stream_reset_outputs", out_bundle(), 64'(0));
    $display("mid-stream reset applied busy=%0d act_ready=%0d busy_cycles=%0d", busy, act_ready, busy_cycles);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    act_valid = 1'b0;
    exp_busy = 0; exp_stall = 0;
    run_vec(9, post_rst);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
